// File: rtl/rr_log_packer_pkg.sv
// Shared definitions for the logging-bus record packer: FSM state encoding,
// the width of one CHANNEL_WIDTHS entry, and the header field layout.
package rr_log_packer_pkg;

   // Width of each entry in the packed CHANNEL_WIDTHS parameter.
   localparam int RR_CHANNEL_WIDTH_BITS = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_DATA = 2'd2
   } pk_state_e;

   // Header layout: logb mask in the low bits, loge mask directly above it.
   function automatic int hdr_loge_lsb(input int logb_cnt);
      return logb_cnt;
   endfunction

   function automatic int hdr_width(input int logb_cnt, input int loge_cnt);
      return logb_cnt + loge_cnt;
   endfunction

endpackage

// File: rtl/rr_log_packer_if.sv
// Logging-bus input side plus the beat stream output side of the packer.
// master = recorder / trace-writer environment, slave = the packer itself.
interface rr_log_packer_if #(
   parameter int LOGB      = 3,
   parameter int LOGE      = 5,
   parameter int DATA_W    = 36,
   parameter int OUT_WIDTH = 512
);
   logic [LOGB-1:0]      in_logb_valid;
   logic [DATA_W-1:0]    in_logb_data;
   logic [LOGE-1:0]      in_loge_valid;
   logic                 in_ready;
   logic                 out_valid;
   logic [OUT_WIDTH-1:0] out_data;
   logic                 out_last;
   logic                 out_ready;

   modport master (
      output in_logb_valid, in_logb_data, in_loge_valid, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_logb_valid, in_logb_data, in_loge_valid, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/rr_lowest_bit_sel.sv
// Picks the lowest set bit of a mask: one-hot form, binary index, and a flag
// telling whether that bit is the only one left.
module rr_lowest_bit_sel #(
   parameter  int WIDTH = 3,
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0] i_mask,
   output logic [WIDTH-1:0] o_onehot,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_single
);

   // Two's-complement trick isolates the lowest set bit; scan finds its index.
   always_comb begin
      o_onehot = i_mask & (~i_mask + WIDTH'(1));
      o_single = (i_mask != '0) && ((i_mask & (i_mask - WIDTH'(1))) == '0);
      o_idx    = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (i_mask[i]) o_idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/rr_log_packer.sv
// Packs each logging-bus transaction into a header beat followed by one beat
// per asserted logb channel, lowest channel first.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | nothing held; in_ready=1, out_valid=0
//   HDR     | header beat (logb mask, loge mask) presented on the output
//   DATA    | payload beat for the lowest channel not yet emitted
module rr_log_packer
   import rr_log_packer_pkg::*;
#(
   parameter int LOGB_CHANNEL_CNT = 3,
   parameter int LOGE_CHANNEL_CNT = 5,
   parameter logic [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] CHANNEL_WIDTHS =
      {16'd12, 16'd16, 16'd8},
   parameter int OUT_WIDTH = 512
) (
   input logic            clk,
   input logic            sync_rst,
   rr_log_packer_if.slave bus
);

   function automatic int get_offset(input int idx);
      int off = 0;
      for (int k = 0; k < idx; k++) off += int'(CHANNEL_WIDTHS[k]);
      return off;
   endfunction

   localparam int DATA_W       = get_offset(LOGB_CHANNEL_CNT);
   localparam int IDX_W        = (LOGB_CHANNEL_CNT > 1) ? $clog2(LOGB_CHANNEL_CNT) : 1;
   localparam int HDR_W        = hdr_width(LOGB_CHANNEL_CNT, LOGE_CHANNEL_CNT);
   localparam int HDR_LOGE_LSB = hdr_loge_lsb(LOGB_CHANNEL_CNT);

   if (OUT_WIDTH < HDR_W) begin : g_hdr_err
      $error("rr_log_packer: OUT_WIDTH %0d is narrower than header %0d", OUT_WIDTH, HDR_W);
   end

   pk_state_e                   r_state;
   logic [LOGB_CHANNEL_CNT-1:0] r_pend;
   logic [DATA_W-1:0]           r_data;
   logic                        r_out_valid;
   logic                        r_out_last;
   logic [OUT_WIDTH-1:0]        r_out_data;

   logic                        w_xfer;
   logic                        w_acc;
   logic                        w_in_ready;
   logic [LOGB_CHANNEL_CNT-1:0] w_sel_onehot;
   logic [IDX_W-1:0]            w_sel_idx;
   logic                        w_sel_single;
   logic [OUT_WIDTH-1:0]        w_sel_data;
   logic [OUT_WIDTH-1:0]        w_hdr;
   logic [OUT_WIDTH-1:0]        w_chan_ext [LOGB_CHANNEL_CNT];

   // Per-channel zero-extended view of the held data.
   for (genvar g = 0; g < LOGB_CHANNEL_CNT; g++) begin : g_chan
      localparam int OFF = get_offset(g);
      localparam int CW  = int'(CHANNEL_WIDTHS[g]);
      if (CW > OUT_WIDTH) begin : g_err
         $error("rr_log_packer: channel %0d width %0d exceeds OUT_WIDTH %0d", g, CW, OUT_WIDTH);
      end
      logic [OUT_WIDTH-1:0] w_ext;
      // Zero-extend channel slice to a full beat.
      always_comb begin
         w_ext         = '0;
         w_ext[CW-1:0] = r_data[OFF +: CW];
      end
      assign w_chan_ext[g] = w_ext;
   end

   // r_pend holds channels not yet loaded into the output register.
   rr_lowest_bit_sel #(.WIDTH(LOGB_CHANNEL_CNT)) u_sel (
      .i_mask   (r_pend),
      .o_onehot (w_sel_onehot),
      .o_idx    (w_sel_idx),
      .o_single (w_sel_single)
   );

   // Mux the next payload beat by channel index.
   always_comb begin
      w_sel_data = '0;
      for (int i = 0; i < LOGB_CHANNEL_CNT; i++) begin
         if (w_sel_idx == IDX_W'(i)) w_sel_data = w_chan_ext[i];
      end
   end

   // Header beat built straight from the incoming masks.
   always_comb begin
      w_hdr                                     = '0;
      w_hdr[LOGB_CHANNEL_CNT-1:0]               = bus.in_logb_valid;
      w_hdr[HDR_LOGE_LSB +: LOGE_CHANNEL_CNT]   = bus.in_loge_valid;
   end

   assign w_acc      = r_out_valid & bus.out_ready;
   assign w_in_ready = (r_state == ST_IDLE) | (w_acc & r_out_last);
   assign w_xfer     = w_in_ready & ((|bus.in_logb_valid) | (|bus.in_loge_valid));

   // Record sequencer; a transfer always (re)loads the header, which gives
   // back-to-back records when it coincides with the final beat.
   always_ff @(posedge clk) begin
      if (sync_rst) begin
         r_state     <= ST_IDLE;
         r_pend      <= '0;
         r_data      <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_data  <= '0;
      end else if (w_xfer) begin
         r_state     <= ST_HDR;
         r_data      <= bus.in_logb_data;
         r_pend      <= bus.in_logb_valid;
         r_out_valid <= 1'b1;
         r_out_data  <= w_hdr;
         r_out_last  <= ~|bus.in_logb_valid;
      end else if (w_acc) begin
         if (r_out_last) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
         end else begin
            r_state    <= ST_DATA;
            r_out_data <= w_sel_data;
            r_out_last <= w_sel_single;
            r_pend     <= r_pend & ~w_sel_onehot;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_last  = r_out_last;

endmodule
